store_data_mem: RTL and testbench

- Data memory for the MIPS pipeline's MEM stage, handling the store side of partial-word access: SB, SH and SW.
- Computes byte enables from opcode and address, and merges the store data into the addressed word on the clock edge.
- Provides the raw aligned word for the load-extraction logic.
- Flags store address exceptions (AdES) to the CP0/interrupt logic and suppresses the write when one is raised.

---
 rtl/store_data_mem_pkg.sv | 26 ++
 rtl/store_data_mem_if.sv | 22 ++
 rtl/store_be_gen.sv | 59 +++++
 rtl/store_data_mem.sv | 75 +++++++
 tb/tb_store_data_mem.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/store_data_mem_pkg.sv
// rtl/store_data_mem_pkg.sv - opcode constants and shared types for the MEM-stage data memory.
package store_data_mem_pkg;

  localparam int BE_W = 4;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef struct packed {
    logic [BE_W-1:0] be;
    logic [31:0]     lane;
    logic            ades;
  } store_ctl_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/store_data_mem_if.sv
// rtl/store_data_mem_if.sv - MEM-stage bus between the pipeline and the data memory.
interface store_data_mem_if;
  logic [31:0] Ins;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        WE;
  logic [31:0] PC;
  logic [31:0] RData;
  logic [3:0]  BE;
  logic        AdES;
  logic [31:0] StoreCnt;

  modport master (
    output Ins, Addr, WData, WE, PC,
    input  RData, BE, AdES, StoreCnt
  );

  modport slave (
    input  Ins, Addr, WData, WE, PC,
    output RData, BE, AdES, StoreCnt
  );
endinterface

// File: rtl/store_be_gen.sv
// rtl/store_be_gen.sv - byte enables, lane replication and AdES detection for SB/SH/SW.
module store_be_gen
  import store_data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic [31:0] i_ins,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  output store_ctl_t  o_ctl
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [5:0]      w_op;
  logic            w_is_store;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic [BE_W-1:0] w_be_raw;
  logic [31:0]     w_lane;
  logic            w_ades;
  logic            w_unused_ins;

  assign w_op           = i_ins[31:26];
  assign w_unused_ins   = ^i_ins[25:0];
  assign w_is_store     = is_store(w_op);
  assign w_out_of_range = {1'b0, i_addr} >= ADDR_LIMIT;

  always_comb begin
    w_be_raw     = '0;
    w_lane       = i_wdata;
    w_misaligned = 1'b0;
    case (w_op)
      OP_SB: begin
        w_be_raw = 4'b0001 << i_addr[1:0];
        w_lane   = {4{i_wdata[7:0]}};
      end
      OP_SH: begin
        w_be_raw     = i_addr[1] ? 4'b1100 : 4'b0011;
        w_lane       = {2{i_wdata[15:0]}};
        w_misaligned = i_addr[0];
      end
      OP_SW: begin
        w_be_raw     = 4'b1111;
        w_misaligned = (i_addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // A flushed MEM stage (WE=0) must never raise AdES for a stale store.
  assign w_ades = i_we && w_is_store && (w_misaligned || w_out_of_range);

  assign o_ctl.be   = (i_we && w_is_store && !w_ades) ? w_be_raw : '0;
  assign o_ctl.lane = w_lane;
  assign o_ctl.ades = w_ades;

endmodule

// File: rtl/store_data_mem.sv
// rtl/store_data_mem.sv - MEM-stage data memory with byte-lane store merge and store counter.
// Optional commit trace enabled by defining STORE_LOG_EN.
module store_data_mem
  import store_data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  store_data_mem_if.slave  s_bus
);

  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [31:0]       r_store_cnt;

  store_ctl_t        w_ctl;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_old;
  logic [31:0]       w_merged;
  logic              w_commit;
  logic              w_unused_pc;

  store_be_gen #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_be_gen (
    .i_ins   (s_bus.Ins),
    .i_addr  (s_bus.Addr),
    .i_wdata (s_bus.WData),
    .i_we    (s_bus.WE),
    .o_ctl   (w_ctl)
  );

  // Out-of-range addresses alias into the array on reads; the load bridge filters them.
  assign w_idx       = s_bus.Addr[ADDR_W+1:2];
  assign w_old       = r_mem[w_idx];
  assign w_commit    = (w_ctl.be != '0);
  assign w_unused_pc = ^s_bus.PC;

  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < BE_W; b++) begin
      if (w_ctl.be[b]) begin
        w_merged[8*b +: 8] = w_ctl.lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
      r_store_cnt <= '0;
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
      r_store_cnt  <= r_store_cnt + 32'd1;
    end
  end

`ifdef STORE_LOG_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_commit) begin
      $display("%0t@%h: *%h <= %h", $time, s_bus.PC, {s_bus.Addr[31:2], 2'b00}, w_merged);
    end
  end
`else
`endif

  assign s_bus.RData    = w_old;
  assign s_bus.BE       = w_ctl.be;
  assign s_bus.AdES     = w_ctl.ades;
  assign s_bus.StoreCnt = r_store_cnt;

endmodule

// File: tb/tb_store_data_mem.sv
// tb/tb_store_data_mem.sv - self-checking bench for store_data_mem against a byte-addressed model.
module tb_store_data_mem;
  import store_data_mem_pkg::*;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_data_mem_if bus ();

  store_data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(12)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .s_bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mbytes [DEPTH*4];
  logic [31:0] mcnt;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  be;
    logic        ades;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int base;
    base = int'((addr >> 2) % DEPTH) * 4;
    return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
  endfunction

  // Store size from the opcode; alignment and range from plain arithmetic.
  function automatic void model_eval(input logic [5:0] op, input logic [31:0] addr,
                                     input logic we, output logic [3:0] be, output logic ades);
    int size;
    size = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : (op == OP_SW) ? 4 : 0;
    ades = we && (size != 0) && (((addr % size) != 0) || ({1'b0, addr} >= 33'(DEPTH * 4)));
    be = 4'b0000;
    if (we && size != 0 && !ades)
      for (int k = 0; k < size; k++) be[int'(addr % 4) + k] = 1'b1;
  endfunction

  function automatic void model_commit(input logic [5:0] op, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic we);
    logic [3:0] be;
    logic ades;
    int size;
    model_eval(op, addr, we, be, ades);
    if (be != 0) begin
      size = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
      for (int k = 0; k < size; k++) mbytes[int'(addr) + k] = wd[8*k +: 8];
      mcnt = mcnt + 1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH*4; i++) mbytes[i] = 8'h00;
    mcnt = 0;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic we);
    bus.Ins   = {op, 26'h0};
    bus.Addr  = addr;
    bus.WData = wd;
    bus.WE    = we;
    bus.PC    = 32'h0040_0000 + (addr & 32'hFC);
  endtask

  // One cycle: drive after negedge, check combinational outputs, clock, check state.
  task automatic step(input string name, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic we,
                      input logic [3:0] exp_be, input logic exp_ades);
    @(negedge clk);
    drive(op, addr, wd, we);
    #1;
    chk({name, ".be"},   32'(bus.BE),   32'(exp_be));
    chk({name, ".ades"}, 32'(bus.AdES), 32'(exp_ades));
    chk({name, ".rd_pre"}, bus.RData, model_word(addr));
    @(posedge clk);
    model_commit(op, addr, wd, we);
    #1;
    chk({name, ".rd_post"}, bus.RData, model_word(addr));
    chk({name, ".cnt"}, bus.StoreCnt, mcnt);
  endtask

  task automatic do_reset(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    reset = 1'b1;
    drive(op, addr, wd, 1'b1);
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    drive(OP_LW, addr, 32'h0, 1'b0);
    #1;
  endtask

  vec_t vecs [12];

  initial begin
    logic [3:0]  rbe;
    logic        rades;
    logic [5:0]  rop;
    logic [31:0] raddr;
    logic [31:0] rwd;
    logic        rwe;
    int          sel;

    reset = 1'b0;
    drive(OP_LW, 32'h0, 32'h0, 1'b0);
    model_reset();

    vecs[0]  = '{OP_SB, 32'h0000_0000, 32'h0000_00A1, 1'b1, 4'b0001, 1'b0};
    vecs[1]  = '{OP_SB, 32'h0000_0001, 32'h0000_00B2, 1'b1, 4'b0010, 1'b0};
    vecs[2]  = '{OP_SB, 32'h0000_0002, 32'h0000_00C3, 1'b1, 4'b0100, 1'b0};
    vecs[3]  = '{OP_SB, 32'h0000_0003, 32'h0000_00D4, 1'b1, 4'b1000, 1'b0};
    vecs[4]  = '{OP_SH, 32'h0000_0004, 32'h0000_1234, 1'b1, 4'b0011, 1'b0};
    vecs[5]  = '{OP_SH, 32'h0000_0006, 32'h0000_5678, 1'b1, 4'b1100, 1'b0};
    vecs[6]  = '{OP_SH, 32'h0000_0005, 32'h0000_9999, 1'b1, 4'b0000, 1'b1};
    vecs[7]  = '{OP_SW, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0};
    vecs[8]  = '{OP_SW, 32'h0000_000A, 32'h1111_1111, 1'b1, 4'b0000, 1'b1};
    vecs[9]  = '{OP_SW, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b1, 4'b1111, 1'b0};
    vecs[10] = '{OP_SB, 32'h0000_4000, 32'h0000_0077, 1'b1, 4'b0000, 1'b1};
    vecs[11] = '{OP_LW, 32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 4'b0000, 1'b0};

    do_reset(OP_LW, 32'h10, 32'h0);
    chk("reset.rdata", bus.RData, 32'h0);
    chk("reset.cnt", bus.StoreCnt, 32'h0);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].we,
           vecs[i].be, vecs[i].ades);
    chk("vec.word0", model_word(32'h0), 32'hD4C3_B2A1);
    chk("vec.word1", model_word(32'h4), 32'h5678_1234);

    do_reset(OP_LW, 32'h0, 32'h0);
    chk("reset2.rdata", bus.RData, 32'h0);

    step("sw10", OP_SW, 32'h10, 32'h1234_5678, 1'b1, 4'b1111, 1'b0);
    chk("sw10.rdata", bus.RData, 32'h1234_5678);
    chk("sw10.cnt", bus.StoreCnt, 32'd1);
    step("sb11", OP_SB, 32'h11, 32'h0000_00AB, 1'b1, 4'b0010, 1'b0);
    chk("sb11.rdata", bus.RData, 32'h1234_AB78);
    step("sh12", OP_SH, 32'h12, 32'h0000_CDEF, 1'b1, 4'b1100, 1'b0);
    chk("sh12.rdata", bus.RData, 32'hCDEF_AB78);
    step("sh13", OP_SH, 32'h13, 32'h0000_1111, 1'b1, 4'b0000, 1'b1);
    chk("sh13.cnt", bus.StoreCnt, 32'd3);
    step("sw16", OP_SW, 32'h16, 32'h2222_2222, 1'b1, 4'b0000, 1'b1);
    chk("sw16.word", model_word(32'h14), 32'h0);
    step("sw4000", OP_SW, 32'h4000, 32'h3333_3333, 1'b1, 4'b0000, 1'b1);
    step("sw4000_we0", OP_SW, 32'h4000, 32'h3333_3333, 1'b0, 4'b0000, 1'b0);
    chk("oor.word0", model_word(32'h0), 32'h0);

    @(negedge clk);
    drive(OP_SW, 32'h20, 32'hFFFF_FFFF, 1'b1);
    #1;
    chk("rdw.before", bus.RData, 32'h0);
    @(posedge clk);
    model_commit(OP_SW, 32'h20, 32'hFFFF_FFFF, 1'b1);
    #1;
    chk("rdw.after", bus.RData, 32'hFFFF_FFFF);

    step("acc_sb0", OP_SB, 32'h30, 32'h0000_0011, 1'b1, 4'b0001, 1'b0);
    step("acc_sb3", OP_SB, 32'h33, 32'h0000_0044, 1'b1, 4'b1000, 1'b0);
    chk("acc.rdata", bus.RData, 32'h4400_0011);

    do_reset(OP_SW, 32'h10, 32'h55);
    chk("rst_store.rdata", bus.RData, 32'h0);
    chk("rst_store.cnt", bus.StoreCnt, 32'h0);

    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      raddr = $urandom_range(0, 63);
      else if (sel < 9) raddr = $urandom_range(0, DEPTH*4 - 1);
      else              raddr = 32'(DEPTH*4) + ($urandom % 32'hFFFF_0000);
      sel = int'($urandom_range(0, 3));
      rop = (sel == 0) ? OP_SB : (sel == 1) ? OP_SH : (sel == 2) ? OP_SW : OP_LW;
      rwd = $urandom;
      rwe = ($urandom_range(0, 99) < 85);
      model_eval(rop, raddr, rwe, rbe, rades);
      step("rand", rop, raddr, rwd, rwe, rbe, rades);
    end

    do_reset(OP_LW, 32'h0, 32'h0);
    chk("final_reset.cnt", bus.StoreCnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
